// File: rtl/gate_check_pkg.sv
// Shared encodings for the gate response checker: reference-function opcodes
// and checker FSM states.
package gate_check_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational bitwise reference for the logic-unit gates; also reused by the
// ALU logic-unit checks.
module gate_ref_model
    import gate_check_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] expected
);

    always_comb begin
        expected = '0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_XOR:  expected = a ^ b;
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// On-chip response checker: compares observed gate samples against a reference
// function, counts passes/fails and records the first failing vector index.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int VEC_COUNT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic [WIDTH-1:0] s_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             cfg_err
);

    localparam int IDX_W = (VEC_COUNT > 1) ? $clog2(VEC_COUNT) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] expected;
    logic             hs;
    logic             match;
    logic             last;
    logic             start_ok;
    logic             start_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    gate_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a        (s_a),
        .b        (s_b),
        .op       (op_q),
        .expected (expected)
    );

    assign hs        = s_valid && (state == CHECK);
    assign match     = (expected == s_out);
    assign last      = (idx == IDX_W'(VEC_COUNT - 1));
    assign start_ok  = start && (state != CHECK) && (op != OP_RSVD);
    assign start_bad = start && (state != CHECK) && (op == OP_RSVD);

    // Handshake and status flags are plain decodes of the registered state.
    assign s_ready = (state == CHECK);
    assign busy    = (state == CHECK);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok)       state_nxt = CHECK;
                else if (start_bad) state_nxt = IDLE;
            end
            CHECK: begin
                if (hs && last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q             <= OP_AND;
            idx              <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            cfg_err          <= 1'b0;
        end else if (start_ok) begin
            op_q             <= op;
            idx              <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            cfg_err          <= 1'b0;
        end else if (start_bad) begin
            cfg_err <= 1'b1;
        end else if (hs) begin
            if (match) begin
                pass_cnt <= sat_inc(pass_cnt);
            end else begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= CNT_W'(idx);
                end
            end
            // Hold on the final vector so the index cannot wrap inside a run.
            if (!last) idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench for gate_vector_checker: a WIDTH=1 instance for functional
// runs and a narrow-counter instance for saturation.
module tb_gate_vector_checker;
    import gate_check_pkg::*;

    localparam int VEC = 4;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_ready, busy, done, ffv, cfg_err;
    logic [1:0]  op;
    logic [0:0]  s_a, s_b, s_out;
    logic [15:0] pass_cnt, fail_cnt, ffi;

    logic        start2, s_valid2, s_ready2, busy2, done2, ffv2, cfg_err2;
    logic [1:0]  op2;
    logic [3:0]  s_a2, s_b2, s_out2;
    logic [1:0]  pass2, fail2, ffi2;

    typedef struct packed {
        logic [15:0] pass;
        logic [15:0] fail;
        logic        ffv;
        logic [15:0] ffi;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] m_pass, m_fail, m_ffi;
    logic        m_ffv, m_busy, m_done, m_cfg;
    logic [1:0]  m_op;
    int          m_idx;

    always #5 clk = ~clk;

    gate_vector_checker #(.WIDTH(1), .VEC_COUNT(VEC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .s_valid(s_valid),
        .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_out(s_out), .busy(busy),
        .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_valid(ffv), .first_fail_idx(ffi), .cfg_err(cfg_err)
    );

    gate_vector_checker #(.WIDTH(4), .VEC_COUNT(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .s_valid(s_valid2),
        .s_ready(s_ready2), .s_a(s_a2), .s_b(s_b2), .s_out(s_out2), .busy(busy2),
        .done(done2), .pass_cnt(pass2), .fail_cnt(fail2),
        .first_fail_valid(ffv2), .first_fail_idx(ffi2), .cfg_err(cfg_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tb_ref(input logic a, input logic b, input logic [1:0] o);
        case (o)
            2'b00:   return a && b;
            2'b01:   return a || b;
            2'b10:   return a != b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_pass = '0; m_fail = '0; m_ffv = 1'b0; m_ffi = '0; m_idx = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".s_ready"}, 32'(s_ready), 32'(m_busy));
        check({tag, ".busy"},    32'(busy),    32'(m_busy));
        check({tag, ".done"},    32'(done),    32'(m_done));
        check({tag, ".pass"},    32'(pass_cnt), 32'(m_pass));
        check({tag, ".fail"},    32'(fail_cnt), 32'(m_fail));
        check({tag, ".ffv"},     32'(ffv),     32'(m_ffv));
        check({tag, ".ffi"},     32'(ffi),     32'(m_ffi));
        check({tag, ".cfg_err"}, 32'(cfg_err), 32'(m_cfg));
    endtask

    task automatic do_start(input logic [1:0] o);
        start = 1'b1; op = o; s_valid = 1'b0;
        if (o == 2'b11) begin
            m_cfg = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            model_clear();
            m_op = o; m_busy = 1'b1; m_done = 1'b0; m_cfg = 1'b0;
        end
        tick();
        start = 1'b0;
        check_all("start");
    endtask

    task automatic offer(input logic a, input logic b, input logic o, input logic v);
        exp_t e;
        s_a = a; s_b = b; s_out = o; s_valid = v;
        check("pre.s_ready", 32'(s_ready), 32'(m_busy));
        if (v && m_busy) begin
            if (o == tb_ref(a, b, m_op)) m_pass++;
            else begin
                m_fail++;
                if (!m_ffv) begin m_ffv = 1'b1; m_ffi = 16'(m_idx); end
            end
            m_idx++;
            if (m_idx == VEC) begin m_busy = 1'b0; m_done = 1'b1; end
            e.pass = m_pass; e.fail = m_fail; e.ffv = m_ffv; e.ffi = m_ffi; e.done = m_done;
            sb.push_back(e);
        end
        tick();
        s_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb.pass", 32'(pass_cnt), 32'(e.pass));
            check("sb.fail", 32'(fail_cnt), 32'(e.fail));
            check("sb.ffv",  32'(ffv),      32'(e.ffv));
            check("sb.ffi",  32'(ffi),      32'(e.ffi));
            check("sb.done", 32'(done),     32'(e.done));
            check("sb.busy", 32'(busy),     32'(!e.done));
        end else begin
            check("drop.pass", 32'(pass_cnt), 32'(m_pass));
            check("drop.fail", 32'(fail_cnt), 32'(m_fail));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; s_valid = 1'b0;
        s_a = '0; s_b = '0; s_out = '0;
        start2 = 1'b0; op2 = 2'b00; s_valid2 = 1'b0; s_a2 = '0; s_b2 = '0; s_out2 = '0;
        model_clear();
        m_op = 2'b00; m_busy = 1'b0; m_done = 1'b0; m_cfg = 1'b0;
        tick(); tick();
        check_all("reset");
        rst = 1'b0;

        // Exhaustive AND, back-to-back, then a sample offered in DONE.
        do_start(2'b00);
        offer(0, 0, 0, 1); offer(0, 1, 0, 1); offer(1, 0, 0, 1); offer(1, 1, 1, 1);
        offer(1, 1, 1, 1);
        check_all("and.end");

        // XOR with the 2nd and 4th outputs corrupted.
        do_start(2'b10);
        offer(0, 0, 0, 1); offer(0, 1, 0, 1); offer(1, 0, 1, 1); offer(1, 1, 1, 1);
        check_all("xor.end");

        // Gapped OR; a start with a new op mid-run must be ignored.
        do_start(2'b01);
        offer(0, 0, 0, 1); offer(0, 0, 0, 0); offer(0, 0, 0, 0);
        start = 1'b1; op = 2'b11;
        tick();
        start = 1'b0; op = 2'b00;
        check_all("ign_start");
        offer(0, 1, 1, 1); offer(0, 0, 0, 0); offer(0, 0, 0, 0);
        offer(1, 0, 1, 1); offer(0, 0, 0, 0); offer(0, 0, 0, 0);
        offer(1, 1, 1, 1); offer(0, 0, 0, 0);
        offer(0, 1, 0, 1);
        check_all("or.end");

        // Reserved op from DONE, sample in IDLE dropped, then a valid start.
        do_start(2'b11);
        offer(1, 1, 0, 1);
        do_start(2'b00);
        offer(1, 1, 1, 1); offer(1, 0, 0, 1); offer(1, 1, 0, 1); offer(0, 0, 1, 1);
        check_all("and2.end");

        // Reset mid-run with start held: reset wins, then a clean XOR run.
        do_start(2'b01);
        offer(0, 1, 1, 1); offer(1, 1, 0, 1);
        rst = 1'b1; start = 1'b1; op = 2'b10;
        tick();
        rst = 1'b0; start = 1'b0;
        model_clear();
        m_busy = 1'b0; m_done = 1'b0; m_cfg = 1'b0;
        check_all("rst_mid");
        do_start(2'b10);
        offer(1, 0, 1, 1); offer(1, 1, 0, 1); offer(0, 0, 0, 1); offer(0, 1, 1, 1);
        check_all("xor2.end");

        // Saturating counters on the narrow instance.
        start2 = 1'b1; op2 = 2'b00;
        tick();
        start2 = 1'b0;
        check("sat.busy", 32'(busy2), 32'(1));
        for (int k = 1; k <= 6; k++) begin
            s_a2 = 4'($urandom); s_b2 = 4'($urandom);
            s_out2 = s_a2 & s_b2; s_valid2 = 1'b1;
            tick();
            check("sat.pass", 32'(pass2), (k < 3) ? k : 3);
            check("sat.done", 32'(done2), 32'(k == 6));
        end
        s_valid2 = 1'b0;
        check("sat.fail", 32'(fail2), 32'(0));
        check("sat.ffv",  32'(ffv2),  32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
